multicycle_control: RTL and testbench



---
 rtl/control_pkg.sv | 65 ++++++
 rtl/control_out_decode.sv | 94 +++++++++
 rtl/multicycle_control.sv | 117 +++++++++++
 tb/tb_multicycle_control.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// Shared encodings for the multicycle control FSM and its output decoder.
// RV_CSR_EN enables the CSR class; when undefined code[9] is an illegal class.
package control_pkg;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_HALT   = 3'd5;

  localparam int unsigned CODE_J     = 0;
  localparam int unsigned CODE_JALR  = 1;
  localparam int unsigned CODE_LUI   = 2;
  localparam int unsigned CODE_AUIPC = 3;
  localparam int unsigned CODE_B     = 4;
  localparam int unsigned CODE_R     = 5;
  localparam int unsigned CODE_S     = 6;
  localparam int unsigned CODE_I     = 7;
  localparam int unsigned CODE_LOAD  = 8;
  localparam int unsigned CODE_CSR   = 9;

  localparam logic [1:0] PC_SEL_PC4  = 2'b00;
  localparam logic [1:0] PC_SEL_IMM  = 2'b01;
  localparam logic [1:0] PC_SEL_JALR = 2'b10;

  localparam logic [1:0] ALU_A_RS1  = 2'b00;
  localparam logic [1:0] ALU_A_PC   = 2'b01;
  localparam logic [1:0] ALU_A_ZERO = 2'b10;

  localparam logic ALU_B_RS2 = 1'b0;
  localparam logic ALU_B_IMM = 1'b1;

  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_PC4 = 2'b10;
  localparam logic [1:0] WB_SEL_CSR = 2'b11;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       ir_load;
    logic       pc_load;
    logic [1:0] pc_sel;
    logic [1:0] alu_a_sel;
    logic       alu_b_sel;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       csr_we;
  } ctrl_t;

  // A class word is legal when exactly one supported class bit is set.
  function automatic logic code_legal(input logic [9:0] c);
    int unsigned n = 0;
    for (int i = 0; i < 10; i++) begin
      n = n + 32'(c[i]);
    end
`ifndef RV_CSR_EN
    if (c[CODE_CSR]) return 1'b0;
`endif
    return n == 1;
  endfunction

endpackage

// File: rtl/control_out_decode.sv
// Combinational map from FSM state and class word to datapath control strobes.
// CSR strobes exist only when RV_CSR_EN is defined.
module control_out_decode
  import control_pkg::*;
(
  input  logic [2:0] i_state,
  input  logic [9:0] i_code,
  input  logic       i_branch_taken,
  input  logic       i_mem_ready,
  output ctrl_t      o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      ST_FETCH: begin
        o_ctrl.mem_req      = 1'b1;
        o_ctrl.mem_addr_sel = 1'b0;
        o_ctrl.ir_load      = i_mem_ready;
      end
      ST_EXEC: begin
        unique case (1'b1)
          i_code[CODE_R]: begin
            o_ctrl.alu_a_sel = ALU_A_RS1;
            o_ctrl.alu_b_sel = ALU_B_RS2;
          end
          i_code[CODE_I], i_code[CODE_LOAD], i_code[CODE_S]: begin
            o_ctrl.alu_a_sel = ALU_A_RS1;
            o_ctrl.alu_b_sel = ALU_B_IMM;
          end
          i_code[CODE_LUI]: begin
            o_ctrl.alu_a_sel = ALU_A_ZERO;
            o_ctrl.alu_b_sel = ALU_B_IMM;
          end
          i_code[CODE_AUIPC]: begin
            o_ctrl.alu_a_sel = ALU_A_PC;
            o_ctrl.alu_b_sel = ALU_B_IMM;
          end
          i_code[CODE_B]: begin
            o_ctrl.alu_a_sel = ALU_A_RS1;
            o_ctrl.alu_b_sel = ALU_B_RS2;
            o_ctrl.pc_load   = 1'b1;
            o_ctrl.pc_sel    = i_branch_taken ? PC_SEL_IMM : PC_SEL_PC4;
          end
          i_code[CODE_J]: begin
            o_ctrl.reg_write = 1'b1;
            o_ctrl.wb_sel    = WB_SEL_PC4;
            o_ctrl.pc_load   = 1'b1;
            o_ctrl.pc_sel    = PC_SEL_IMM;
          end
          i_code[CODE_JALR]: begin
            o_ctrl.reg_write = 1'b1;
            o_ctrl.wb_sel    = WB_SEL_PC4;
            o_ctrl.pc_load   = 1'b1;
            o_ctrl.pc_sel    = PC_SEL_JALR;
          end
          i_code[CODE_CSR]: begin
`ifdef RV_CSR_EN
            o_ctrl.csr_we    = 1'b1;
            o_ctrl.alu_a_sel = ALU_A_RS1;
`endif
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        o_ctrl.mem_req      = 1'b1;
        o_ctrl.mem_addr_sel = 1'b1;
        o_ctrl.mem_we       = i_code[CODE_S];
        // A completing store retires here; loads still need WB.
        if (i_code[CODE_S] && i_mem_ready) begin
          o_ctrl.pc_load = 1'b1;
          o_ctrl.pc_sel  = PC_SEL_PC4;
        end
      end
      ST_WB: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.pc_load   = 1'b1;
        o_ctrl.pc_sel    = PC_SEL_PC4;
        if (i_code[CODE_LOAD]) begin
          o_ctrl.wb_sel = WB_SEL_MEM;
`ifdef RV_CSR_EN
        end else if (i_code[CODE_CSR]) begin
          o_ctrl.wb_sel = WB_SEL_CSR;
`endif
        end else begin
          o_ctrl.wb_sel = WB_SEL_ALU;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV64 control FSM: state register, memory wait counter, sticky fault.
// Build with RV_CSR_EN defined to accept the CSR class.
module multicycle_control
  import control_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] code,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_addr_sel,
  output logic       ir_load,
  output logic       pc_load,
  output logic [1:0] pc_sel,
  output logic [1:0] alu_a_sel,
  output logic       alu_b_sel,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic       csr_we,
  output logic       fault,
  output logic [2:0] state
);

  localparam int unsigned CntW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

  logic [2:0]      r_state;
  logic [2:0]      w_state_d;
  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_d;
  logic            r_fault;
  logic            w_fault_d;
  ctrl_t           w_dec;
  ctrl_t           w_ctrl;
  logic            w_wait;
  logic            w_timeout;

  control_out_decode u_out_decode (
    .i_state        (r_state),
    .i_code         (code),
    .i_branch_taken (branch_taken),
    .i_mem_ready    (mem_ready),
    .o_ctrl         (w_dec)
  );

  assign w_wait    = w_dec.mem_req && !mem_ready;
  assign w_timeout = (MEM_TIMEOUT != 0) && w_wait &&
                     (r_cnt == CntW'(MEM_TIMEOUT - 1));

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      ST_FETCH: begin
        if (mem_ready)      w_state_d = ST_DECODE;
        else if (w_timeout) w_state_d = ST_HALT;
      end
      ST_DECODE: w_state_d = code_legal(code) ? ST_EXEC : ST_HALT;
      ST_EXEC: begin
        if (code[CODE_LOAD] || code[CODE_S]) begin
          w_state_d = ST_MEM;
        end else if (code[CODE_B] || code[CODE_J] || code[CODE_JALR]) begin
          w_state_d = ST_FETCH;
        end else begin
          w_state_d = ST_WB;
        end
      end
      ST_MEM: begin
        if (mem_ready)      w_state_d = code[CODE_LOAD] ? ST_WB : ST_FETCH;
        else if (w_timeout) w_state_d = ST_HALT;
      end
      ST_WB:   w_state_d = ST_FETCH;
      default: w_state_d = ST_HALT;
    endcase
  end

  // The wait counter restarts on every state change so FETCH and MEM budgets are independent.
  always_comb begin
    if (w_state_d != r_state) w_cnt_d = '0;
    else if (w_wait)          w_cnt_d = r_cnt + CntW'(1);
    else                      w_cnt_d = r_cnt;
  end

  assign w_fault_d = r_fault || (w_state_d == ST_HALT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_FETCH;
      r_cnt   <= '0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_fault <= w_fault_d;
    end
  end

  // Reset forces every strobe low combinationally, so an abort drops them at once.
  assign w_ctrl = reset ? '0 : w_dec;

  assign mem_req      = w_ctrl.mem_req;
  assign mem_we       = w_ctrl.mem_we;
  assign mem_addr_sel = w_ctrl.mem_addr_sel;
  assign ir_load      = w_ctrl.ir_load;
  assign pc_load      = w_ctrl.pc_load;
  assign pc_sel       = w_ctrl.pc_sel;
  assign alu_a_sel    = w_ctrl.alu_a_sel;
  assign alu_b_sel    = w_ctrl.alu_b_sel;
  assign reg_write    = w_ctrl.reg_write;
  assign wb_sel       = w_ctrl.wb_sel;
  assign csr_we       = w_ctrl.csr_we;
  assign fault        = r_fault;
  assign state        = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control; per-cycle expectations are queued with stimulus.
module tb_multicycle_control;

  localparam logic [9:0] C_J    = 10'b0000000001;
  localparam logic [9:0] C_JALR = 10'b0000000010;
  localparam logic [9:0] C_LUI  = 10'b0000000100;
  localparam logic [9:0] C_AUI  = 10'b0000001000;
  localparam logic [9:0] C_B    = 10'b0000010000;
  localparam logic [9:0] C_R    = 10'b0000100000;
  localparam logic [9:0] C_S    = 10'b0001000000;
  localparam logic [9:0] C_I    = 10'b0010000000;
  localparam logic [9:0] C_LD   = 10'b0100000000;
  localparam logic [9:0] C_CSR  = 10'b1000000000;

  // {mem_req, mem_we, addr_sel, ir_load, pc_load, pc_sel, alu_a, alu_b, reg_write, wb_sel, csr_we}
  localparam logic [13:0] NONE   = 14'b0_0_0_0_0_00_00_0_0_00_0;
  localparam logic [13:0] F_WAIT = 14'b1_0_0_0_0_00_00_0_0_00_0;
  localparam logic [13:0] F_RDY  = 14'b1_0_0_1_0_00_00_0_0_00_0;
  localparam logic [13:0] EX_IMM = 14'b0_0_0_0_0_00_00_1_0_00_0;
  localparam logic [13:0] EX_LUI = 14'b0_0_0_0_0_00_10_1_0_00_0;
  localparam logic [13:0] EX_AUI = 14'b0_0_0_0_0_00_01_1_0_00_0;
  localparam logic [13:0] EX_BT  = 14'b0_0_0_0_1_01_00_0_0_00_0;
  localparam logic [13:0] EX_BN  = 14'b0_0_0_0_1_00_00_0_0_00_0;
  localparam logic [13:0] EX_J   = 14'b0_0_0_0_1_01_00_0_1_10_0;
  localparam logic [13:0] EX_JR  = 14'b0_0_0_0_1_10_00_0_1_10_0;
  localparam logic [13:0] EX_CSR = 14'b0_0_0_0_0_00_00_0_0_00_1;
  localparam logic [13:0] MEM_LD = 14'b1_0_1_0_0_00_00_0_0_00_0;
  localparam logic [13:0] MEM_SW = 14'b1_1_1_0_0_00_00_0_0_00_0;
  localparam logic [13:0] MEM_SR = 14'b1_1_1_0_1_00_00_0_0_00_0;
  localparam logic [13:0] WB_ALU = 14'b0_0_0_0_1_00_00_0_1_00_0;
  localparam logic [13:0] WB_MEM = 14'b0_0_0_0_1_00_00_0_1_01_0;
  localparam logic [13:0] WB_CSR = 14'b0_0_0_0_1_00_00_0_1_11_0;

  typedef struct {
    logic [9:0]  code;
    logic        mr;
    logic        bt;
    logic [2:0]  st;
    logic [13:0] v;
    logic        flt;
  } cyc_t;

  logic clk = 1'b0;
  logic reset, branch_taken, mem_ready;
  logic [9:0] code;
  logic mem_req, mem_we, mem_addr_sel, ir_load, pc_load, alu_b_sel, reg_write, csr_we, fault;
  logic [1:0] pc_sel, alu_a_sel, wb_sel;
  logic [2:0] state;
  logic [13:0] ctl;

  cyc_t sb[$];
  int tests_run = 0;
  int tests_failed = 0;

  assign ctl = {mem_req, mem_we, mem_addr_sel, ir_load, pc_load, pc_sel, alu_a_sel, alu_b_sel,
                reg_write, wb_sel, csr_we};

  always #5 clk = ~clk;

  multicycle_control #(.MEM_TIMEOUT(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .code         (code),
    .branch_taken (branch_taken),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr_sel (mem_addr_sel),
    .ir_load      (ir_load),
    .pc_load      (pc_load),
    .pc_sel       (pc_sel),
    .alu_a_sel    (alu_a_sel),
    .alu_b_sel    (alu_b_sel),
    .reg_write    (reg_write),
    .wb_sel       (wb_sel),
    .csr_we       (csr_we),
    .fault        (fault),
    .state        (state)
  );

  function automatic void push(input logic [9:0] c, input logic mr, input logic bt,
                               input logic [2:0] st, input logic [13:0] v, input logic flt);
    sb.push_back('{c, mr, bt, st, v, flt});
  endfunction

  // Release just after a rising edge so the first compared cycle starts with a clean counter.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; mem_ready = 1'b0; branch_taken = 1'b0; code = '0;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    code = C_R; mem_ready = 1'b1; reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #2;
      tests_run++;
      if ({state, ctl, fault} !== 18'd0) begin
        tests_failed++;
        $display("FAIL reset_hold %0d: got st=%0d ctl=%b flt=%b, want all zero", i, state, ctl,
                 fault);
      end
      @(posedge clk);
    end
    @(negedge clk);
    reset = 1'b0; mem_ready = 1'b0;
    #2;
    tests_run++;
    if ({state, ctl, fault} !== {3'd0, F_WAIT, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_release: got st=%0d ctl=%b flt=%b, want st=0 ctl=%b flt=0", state,
               ctl, fault, F_WAIT);
    end
  endtask

  task automatic test_flows(input string name);
    cyc_t e;
    int n = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk);
      code = e.code; mem_ready = e.mr; branch_taken = e.bt;
      #2;
      tests_run++;
      if ({state, ctl, fault} !== {e.st, e.v, e.flt}) begin
        tests_failed++;
        $display("FAIL %s cyc %0d: got st=%0d ctl=%b flt=%b, want st=%0d ctl=%b flt=%b", name, n,
                 state, ctl, fault, e.st, e.v, e.flt);
      end
      n++;
    end
  endtask

  task automatic test_r_flow();
    do_reset();
    // mem_ready held high outside FETCH must be ignored.
    push(C_R, 1, 0, 0, F_RDY, 0); push(C_R, 1, 0, 1, NONE, 0); push(C_R, 1, 0, 2, NONE, 0);
    push(C_R, 1, 0, 4, WB_ALU, 0); push(C_R, 0, 0, 0, F_WAIT, 0);
    test_flows("r_flow");
  endtask

  task automatic test_alu_variants();
    logic [9:0]  codes [3] = '{C_I, C_LUI, C_AUI};
    logic [13:0] exs   [3] = '{EX_IMM, EX_LUI, EX_AUI};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      push(codes[i], 1, 0, 0, F_RDY, 0); push(codes[i], 0, 0, 1, NONE, 0);
      push(codes[i], 0, 0, 2, exs[i], 0); push(codes[i], 0, 0, 4, WB_ALU, 0);
    end
    push(C_R, 0, 0, 0, F_WAIT, 0);
    test_flows("alu_variants");
  endtask

  task automatic test_load_wait();
    do_reset();
    push(C_LD, 1, 0, 0, F_RDY, 0); push(C_LD, 0, 0, 1, NONE, 0); push(C_LD, 0, 0, 2, EX_IMM, 0);
    for (int i = 0; i < 3; i++) push(C_LD, 0, 0, 3, MEM_LD, 0);
    push(C_LD, 1, 0, 3, MEM_LD, 0); push(C_LD, 0, 0, 4, WB_MEM, 0);
    push(C_LD, 0, 0, 0, F_WAIT, 0);
    test_flows("load_wait");
  endtask

  task automatic test_branch_jump();
    do_reset();
    push(C_B, 1, 1, 0, F_RDY, 0); push(C_B, 0, 1, 1, NONE, 0); push(C_B, 0, 1, 2, EX_BT, 0);
    push(C_B, 1, 0, 0, F_RDY, 0); push(C_B, 0, 0, 1, NONE, 0); push(C_B, 1, 0, 2, EX_BN, 0);
    push(C_J, 1, 0, 0, F_RDY, 0); push(C_J, 0, 0, 1, NONE, 0); push(C_J, 0, 0, 2, EX_J, 0);
    push(C_JALR, 1, 0, 0, F_RDY, 0); push(C_JALR, 0, 0, 1, NONE, 0);
    push(C_JALR, 0, 1, 2, EX_JR, 0);
    push(C_JALR, 0, 0, 0, F_WAIT, 0);
    test_flows("branch_jump");
  endtask

  task automatic test_store_reset();
    do_reset();
    push(C_S, 1, 0, 0, F_RDY, 0); push(C_S, 0, 0, 1, NONE, 0); push(C_S, 0, 0, 2, EX_IMM, 0);
    push(C_S, 0, 0, 3, MEM_SW, 0); push(C_S, 1, 0, 3, MEM_SR, 0);
    push(C_S, 1, 0, 0, F_RDY, 0); push(C_S, 0, 0, 1, NONE, 0); push(C_S, 0, 0, 2, EX_IMM, 0);
    push(C_S, 0, 0, 3, MEM_SW, 0);
    test_flows("store");
    #1 reset = 1'b1;
    #1;
    tests_run++;
    if ({state, ctl, fault} !== 18'd0) begin
      tests_failed++;
      $display("FAIL store_abort: got st=%0d ctl=%b flt=%b, want all zero", state, ctl, fault);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    mem_ready = 1'b0;
    #2;
    tests_run++;
    if ({state, ctl, fault} !== {3'd0, F_WAIT, 1'b0}) begin
      tests_failed++;
      $display("FAIL store_restart: got st=%0d ctl=%b flt=%b, want st=0 ctl=%b flt=0", state,
               ctl, fault, F_WAIT);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    push(10'b0000000011, 1, 0, 0, F_RDY, 0); push(10'b0000000011, 0, 0, 1, NONE, 0);
    for (int i = 0; i < 20; i++) push(C_S, i[0], 1, 5, NONE, 1);
    test_flows("illegal_two_hot");
    do_reset();
    push(10'd0, 1, 0, 0, F_RDY, 0); push(10'd0, 0, 0, 1, NONE, 0);
    push(10'd0, 1, 0, 5, NONE, 1); push(C_R, 1, 0, 5, NONE, 1);
    test_flows("illegal_zero");
    @(negedge clk);
    reset = 1'b1;
    #2;
    tests_run++;
    if ({state, fault} !== 4'd0) begin
      tests_failed++;
      $display("FAIL halt_exit: got st=%0d flt=%b, want st=0 flt=0", state, fault);
    end
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < 4; i++) push(C_R, 0, 0, 0, F_WAIT, 0);
    push(C_R, 1, 0, 5, NONE, 1); push(C_R, 0, 0, 5, NONE, 1);
    test_flows("timeout_fetch");
    do_reset();
    // Ready on the limit cycle wins; the MEM budget starts fresh after FETCH waits.
    for (int i = 0; i < 3; i++) push(C_LD, 0, 0, 0, F_WAIT, 0);
    push(C_LD, 1, 0, 0, F_RDY, 0); push(C_LD, 0, 0, 1, NONE, 0); push(C_LD, 0, 0, 2, EX_IMM, 0);
    for (int i = 0; i < 3; i++) push(C_LD, 0, 0, 3, MEM_LD, 0);
    push(C_LD, 1, 0, 3, MEM_LD, 0); push(C_LD, 0, 0, 4, WB_MEM, 0);
    push(C_LD, 1, 0, 0, F_RDY, 0); push(C_LD, 0, 0, 1, NONE, 0); push(C_LD, 0, 0, 2, EX_IMM, 0);
    for (int i = 0; i < 4; i++) push(C_LD, 0, 0, 3, MEM_LD, 0);
    push(C_LD, 1, 0, 5, NONE, 1);
    test_flows("timeout_mem");
  endtask

  task automatic test_csr();
    do_reset();
    push(C_CSR, 1, 0, 0, F_RDY, 0); push(C_CSR, 0, 0, 1, NONE, 0);
`ifdef RV_CSR_EN
    push(C_CSR, 0, 0, 2, EX_CSR, 0); push(C_CSR, 0, 0, 4, WB_CSR, 0);
    push(C_CSR, 0, 0, 0, F_WAIT, 0);
`else
    for (int i = 0; i < 3; i++) push(C_CSR, 1, 0, 5, NONE, 1);
`endif
    test_flows("csr");
  endtask

  initial begin
    reset = 1'b1; code = '0; mem_ready = 1'b0; branch_taken = 1'b0;
    test_reset();
    test_r_flow();
    test_alu_variants();
    test_load_wait();
    test_branch_jump();
    test_store_reset();
    test_illegal();
    test_timeout();
    test_csr();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
